// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state codes, stop-bit
// encoding, bit-period width and helpers used by uart_rx and uart_tx.
package uart_pkg;

   localparam int unsigned DUR_W   = 16;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned STATE_W = 3;

   // FSM state codes
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_START = 3'd1;
   localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
   localparam logic [STATE_W-1:0] ST_STOP  = 3'd3;
   localparam logic [STATE_W-1:0] ST_BREAK = 3'd4;

   // stopbits port encoding; 2'b00 behaves as STOP_1, 2'b11 as STOP_2
   localparam logic [1:0] STOP_1 = 2'b01;
   localparam logic [1:0] STOP_2 = 2'b10;

   // Shortest bit period the receiver will time with
   localparam logic [DUR_W-1:0] DUR_MIN = 16'd4;

   // True when the stopbits code selects two stop bits
   function automatic logic two_stop(input logic [1:0] sb);
      return (sb & STOP_2) != 2'b00;
   endfunction

   // Clamp a requested bit period to the supported minimum
   function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] d);
      return (d < DUR_MIN) ? DUR_MIN : d;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an idle-high asynchronous line.
// Ports: clk, rst (async active-low, flops reset to 1), d (async in), q (synced out).
module uart_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 or 2 stop bits, mid-bit sampling
// timed by a down-counter loaded from bit_duration.
// Ports: clk, rst (async active-low), rx (async serial line, idle high),
//        bit_duration (clk cycles per bit), stopbits (stop-bit code),
//        data (last good byte), data_valid / frame_error (one-cycle pulses),
//        busy (FSM not idle).
module uart_rx
   import uart_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   input  logic [DUR_W-1:0]  bit_duration,
   input  logic [1:0]        stopbits,
   output logic [DATA_W-1:0] data,
   output logic              data_valid,
   output logic              frame_error,
   output logic              busy
);

   logic                rx_s;
   logic                rx_prev;
   logic [1:0]          arm;

   logic [STATE_W-1:0]  state_q, state_d;
   logic [DUR_W-1:0]    cnt_q, cnt_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic                two_q, two_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [2:0]          bit_q, bit_d;
   logic                stop_q, stop_d;
   logic [DATA_W-1:0]   data_d;
   logic                dv_d, fe_d;
   logic                expire;
   logic [DUR_W-1:0]    dur_in;

   uart_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // rx_prev only learns real line samples once the synchronizer has flushed
   // its reset value, so a line held low across reset release is not an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arm     <= 2'b00;
         rx_prev <= 1'b0;
      end else begin
         arm     <= {arm[0], 1'b1};
         rx_prev <= arm[1] & rx_s;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dur_q       <= DUR_MIN;
         two_q       <= 1'b0;
         shift_q     <= '0;
         bit_q       <= '0;
         stop_q      <= 1'b0;
         data        <= '0;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dur_q       <= dur_d;
         two_q       <= two_d;
         shift_q     <= shift_d;
         bit_q       <= bit_d;
         stop_q      <= stop_d;
         data        <= data_d;
         data_valid  <= dv_d;
         frame_error <= fe_d;
         busy        <= (state_d != ST_IDLE);
      end
   end

   // Counter reaching 1 marks a sample point; it is reloaded there, so it never underflows.
   assign expire = (cnt_q <= DUR_W'(1));
   assign dur_in = clamp_dur(bit_duration);

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dur_d   = dur_q;
      two_d   = two_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      data_d  = data;
      dv_d    = 1'b0;
      fe_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_prev && !rx_s) begin
               dur_d   = dur_in;
               two_d   = two_stop(stopbits);
               cnt_d   = dur_in >> 1;
               bit_d   = '0;
               stop_d  = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (expire) begin
               cnt_d   = dur_q;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q - DUR_W'(1);
            end
         end
         ST_DATA: begin
            if (expire) begin
               cnt_d   = dur_q;
               shift_d = {rx_s, shift_q[DATA_W-1:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q - DUR_W'(1);
            end
         end
         ST_STOP: begin
            if (expire) begin
               cnt_d = dur_q;
               if (!rx_s) begin
                  fe_d    = 1'b1;
                  state_d = ST_BREAK;
               end else if (two_q && !stop_q) begin
                  stop_d = 1'b1;
               end else begin
                  dv_d    = 1'b1;
                  data_d  = shift_q;
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - DUR_W'(1);
            end
         end
         ST_BREAK: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a table of frames plus hand-written
// sequences (false start, framing error, back-to-back, reset mid-frame).
// Expected pulses are queued as frames are driven and matched by a monitor.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [15:0] bit_duration = 16'd868;
   logic [1:0]  stopbits = 2'b01;
   logic [7:0]  data;
   logic        data_valid;
   logic        frame_error;
   logic        busy;

   always #5 clk = ~clk;

   uart_rx dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .bit_duration (bit_duration),
      .stopbits     (stopbits),
      .data         (data),
      .data_valid   (data_valid),
      .frame_error  (frame_error),
      .busy         (busy)
   );

   typedef struct {
      logic       err;
      logic [7:0] data;
   } ev_t;

   typedef struct {
      logic [7:0]  b;
      logic [15:0] dur;
      logic [1:0]  sb;
      logic [1:0]  sv;   // stop bit values driven, bit0 = first stop bit
   } vec_t;

   ev_t        exp_q[$];
   ev_t        mon_e;
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] last_good = 8'h00;
   logic       dv_prev = 1'b0;
   logic       fe_prev = 1'b0;
   vec_t       vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic err, input logic [7:0] d);
      ev_t e;
      e.err  = err;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Hold rx at v for n clock cycles; returns just after a rising edge
   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Serialize one frame; port settings are scrambled once the start bit is
   // past so the receiver must rely on its latched copies.
   task automatic send_frame(input logic [7:0] b, input int bd, input logic [15:0] dur_port,
                             input logic [1:0] sb, input int nstop, input logic [1:0] sv,
                             input int tail_low);
      bit_duration = dur_port;
      stopbits     = sb;
      drive(1'b0, bd);
      bit_duration = 16'd7;
      stopbits     = ~sb;
      for (int i = 0; i < 8; i++) drive(b[i], bd);
      for (int s = 0; s < nstop; s++) drive(sv[s], bd);
      if (tail_low > 0) drive(1'b0, tail_low);
   endtask

   task automatic wait_idle(input string name, input int limit);
      int k = 0;
      while (busy && k < limit) begin
         @(posedge clk);
         #1;
         k++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   // Scoreboard monitor: every pulse must match the next queued expectation
   always @(negedge clk) begin
      if (!rst) begin
         dv_prev = 1'b0;
         fe_prev = 1'b0;
      end else begin
         if (data_valid || frame_error) begin
            check("pulse_exclusive", 32'(data_valid & frame_error), 32'd0);
            if ((data_valid && dv_prev) || (frame_error && fe_prev)) begin
               n_checks++;
               n_fail++;
               $display("FAIL pulse_width: dv=%0b fe=%0b high for more than one cycle, expected one", data_valid, frame_error);
            end else if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pulse: dv=%0b fe=%0b data=0x%0h, expected no pulse", data_valid, frame_error, data);
            end else begin
               mon_e = exp_q.pop_front();
               check("event_kind_fe", 32'(frame_error), 32'(mon_e.err));
               check("event_data", 32'(data), 32'(mon_e.data));
            end
         end
         dv_prev = data_valid;
         fe_prev = frame_error;
      end
   end

   initial begin
      int bd;
      int ns;
      logic ok;
      int cyc;

      vecs[0] = '{b: 8'h72, dur: 16'd868, sb: 2'b01, sv: 2'b11};
      vecs[1] = '{b: 8'h0F, dur: 16'd40,  sb: 2'b10, sv: 2'b01};
      vecs[2] = '{b: 8'h0F, dur: 16'd40,  sb: 2'b10, sv: 2'b11};
      vecs[3] = '{b: 8'hA5, dur: 16'd16,  sb: 2'b00, sv: 2'b01};
      vecs[4] = '{b: 8'h5A, dur: 16'd16,  sb: 2'b11, sv: 2'b10};
      vecs[5] = '{b: 8'hC3, dur: 16'd2,   sb: 2'b01, sv: 2'b11};
      vecs[6] = '{b: 8'h81, dur: 16'd3,   sb: 2'b11, sv: 2'b11};
      vecs[7] = '{b: 8'h3C, dur: 16'd100, sb: 2'b01, sv: 2'b00};

      // Reset state
      #2 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("reset_data", 32'(data), 32'h00);
      check("reset_dv", 32'(data_valid), 32'd0);
      check("reset_fe", 32'(frame_error), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      drive(1'b1, 10);

      // Table-driven frames
      foreach (vecs[v]) begin
         bd = (vecs[v].dur < 16'd4) ? 4 : int'(vecs[v].dur);
         ns = (vecs[v].sb == 2'b10 || vecs[v].sb == 2'b11) ? 2 : 1;
         ok = vecs[v].sv[0] && (ns == 1 || vecs[v].sv[1]);
         if (ok) begin
            push_exp(1'b0, vecs[v].b);
            last_good = vecs[v].b;
         end else begin
            push_exp(1'b1, last_good);
         end
         send_frame(vecs[v].b, bd, vecs[v].dur, vecs[v].sb, ns, vecs[v].sv, 0);
         drive(1'b1, 2 * bd);
         wait_idle("vec_idle", 4 * bd);
         check("vec_drained", 32'(exp_q.size()), 32'd0);
         check("vec_data", 32'(data), 32'(last_good));
      end

      // False start: 300 low cycles at 868 cycles/bit
      bit_duration = 16'd868;
      stopbits     = 2'b01;
      drive(1'b0, 10);
      cyc = 10;
      check("false_start_busy_high", 32'(busy), 32'd1);
      drive(1'b0, 290);
      cyc += 290;
      rx = 1'b1;
      while (busy && cyc < 450) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("false_start_busy_low", 32'(busy), 32'd0);
      drive(1'b1, 50);

      // Framing error held as a break for 3 bit times
      push_exp(1'b1, last_good);
      send_frame(8'hA5, 868, 16'd868, 2'b01, 1, 2'b00, 2 * 868);
      check("break_busy", 32'(busy), 32'd1);
      check("break_data_kept", 32'(data), 32'(last_good));
      drive(1'b1, 10);
      wait_idle("break_exit", 100);
      check("break_drained", 32'(exp_q.size()), 32'd0);
      drive(1'b1, 100);

      // Back-to-back frames, zero idle time
      push_exp(1'b0, 8'h00);
      push_exp(1'b0, 8'hFF);
      send_frame(8'h00, 24, 16'd24, 2'b01, 1, 2'b01, 0);
      send_frame(8'hFF, 24, 16'd24, 2'b01, 1, 2'b01, 0);
      last_good = 8'hFF;
      drive(1'b1, 48);
      wait_idle("b2b_idle", 100);
      check("b2b_drained", 32'(exp_q.size()), 32'd0);
      check("b2b_data", 32'(data), 32'hFF);

      // Reset during data bit 4 of 8'h0B; the remaining bits are low so no edge follows
      bit_duration = 16'd20;
      stopbits     = 2'b01;
      drive(1'b0, 20);
      drive(1'b1, 20);
      drive(1'b1, 20);
      drive(1'b0, 20);
      drive(1'b1, 20);
      drive(1'b0, 10);
      rst = 1'b0;
      drive(1'b0, 3);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_data", 32'(data), 32'h00);
      check("midrst_dv", 32'(data_valid), 32'd0);
      rst = 1'b1;
      last_good = 8'h00;
      drive(1'b0, 67);
      check("midrst_no_restart", 32'(busy), 32'd0);
      drive(1'b1, 20);
      drive(1'b1, 40);
      check("midrst_quiet", 32'(exp_q.size()), 32'd0);
      push_exp(1'b0, 8'h3C);
      last_good = 8'h3C;
      send_frame(8'h3C, 20, 16'd20, 2'b01, 1, 2'b01, 0);
      drive(1'b1, 40);
      wait_idle("midrst_idle", 100);
      check("midrst_next_data", 32'(data), 32'h3C);
      check("final_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
